rv32_mem_bridge: RTL and testbench
==================================

# rv32_mem_bridge

Sequential bridge between the RV32 core's native memory handshake (mem_valid/mem_ready) and the system's flat slave bus (addr/wr/din/dout) that feeds the block RAM and memory-mapped peripherals. It latches each core request, drives the slave bus for a fixed number of cycles, waits a parameterised read latency, captures read data and returns a single-cycle mem_ready. Accesses outside the mapped window are blocked from the bus and answered with a fixed error word. Each blocked access is counted and its address recorded.

## Interface
- address_width, 32, width of mem_addr and bus_addr
- data_width, 32, width of all data paths
- read_latency, 1, slave read latency in cycles (1..15); 1 matches the block RAM
- MapBase, 0, lowest mapped byte address (inclusive)
- MapEnd, 32'h0000_FFFF, highest mapped byte address (inclusive)
- ErrorData, 32'hDEAD_BEEF, read data returned for unmapped reads
- clk  in  1  system clock; everything is on the rising edge
- reset  in  1  synchronous, active-high reset
- mem_valid  in  1  core request valid; held until mem_ready
- mem_addr  in  address_width  core byte address
- mem_wdata  in  data_width  core write data
- mem_wstrb  in  4  byte write strobes; 0 = read
- mem_ready  out  1  one-cycle completion pulse
- mem_rdata  out  data_width  read data, valid while mem_ready=1
- bus_addr  out  address_width  slave bus byte address
- bus_wr  out  4  slave byte write enables
- bus_din  out  data_width  slave write data
- bus_dout  in  data_width  slave read data (OR-combined by the system)
- err_count  out  8  saturating count of unmapped accesses
- err_addr  out  address_width  address of the most recent unmapped access

## Operation
- FSM states: IDLE, ACCESS, WAIT, RESP.
- IDLE: when mem_valid=1, latch mem_addr, mem_wdata and mem_wstrb into req registers. Compute `hit = (MapBase <= addr <= MapEnd)`, comparing full-width and unsigned. Go to ACCESS.
- ACCESS (exactly 1 cycle):
  - bus_addr = req addr and bus_din = req wdata.
  - bus_wr = req wstrb if hit, otherwise 0.
  - A write (wstrb≠0) goes to RESP. A read goes to WAIT with the counter set to read_latency−1.
- WAIT: bus_addr is held and bus_wr=0. The counter decrements each cycle.
  - When the counter is 0, register mem_rdata = hit ? bus_dout : ErrorData, then go to RESP.
  - With read_latency=1, WAIT lasts exactly 1 cycle.
- RESP: mem_ready=1 for exactly 1 cycle, then return to IDLE. A mem_valid seen during RESP is not accepted; it is only evaluated again in IDLE.
- bus_addr and bus_din hold the request values from ACCESS through RESP. They return to 0 in IDLE.
- bus_wr is nonzero only in ACCESS, so each write produces exactly one write-enable pulse.
- Unmapped access (hit=0): during ACCESS, err_addr is set to the req addr and err_count increments. err_count saturates at 8'hFF and does not wrap.
- Unmapped writes have no bus effect and still complete normally. Unmapped reads return ErrorData.
- mem_rdata holds its last captured value outside RESP. Write completions do not modify it.

## Timing
- Reset values: mem_ready=0, mem_rdata=0, bus_addr=0, bus_wr=0, bus_din=0, err_count=0, err_addr=0, state=IDLE.
- Latency is counted from the mem_valid edge at cycle 0 (IDLE):
  - write: ACCESS at c1, mem_ready at c2;
  - read: ACCESS at c1, WAIT at c2..c(1+read_latency), mem_ready at c(2+read_latency). This gives c3 for the block RAM.
- Back-to-back requests: the next request is accepted in the IDLE cycle after RESP. The minimum spacing between mem_ready pulses is 3 cycles for writes and 3+read_latency cycles for reads.
- Reset asserted in any state: the next edge forces all reset values and IDLE. The in-flight request is abandoned with no mem_ready and no further bus_wr pulse.
- mem_addr/mem_wdata changes after acceptance are ignored; only the latched req values are used.

## Test plan
- Mapped write, addr=0x10, wdata=0xA5A5_1234, wstrb=4'b0011 -> bus_wr=4'b0011 for exactly one cycle at c1 with bus_addr=0x10; mem_ready single pulse at c2; err_count stays 0.
- Mapped read of addr=0x10 with a 1-cycle-latency RAM model holding 0xCAFE_F00D -> mem_ready at c3 with mem_rdata=0xCAFE_F00D; bus_wr=0 throughout.
- Read with read_latency=4, slave returning 0x1111_2222 -> mem_ready at c6 with the correct data; bus_addr held stable c1..c6.
- Unmapped read at 0x0001_0000 followed by an unmapped write at 0xFFFF_FFFC:
  - read -> mem_rdata=0xDEAD_BEEF and no bus write;
  - write -> bus_wr stays 0;
  - afterwards err_count=2 and err_addr=0xFFFF_FFFC.
  - Further drive 300 unmapped accesses -> err_count=8'hFF.
- Reset pulsed in WAIT of a read -> no mem_ready, all outputs 0 on the next cycle. A fresh write issued afterwards completes at c2.
- mem_valid held continuously through RESP for two consecutive reads -> exactly two mem_ready pulses, separated by 4 cycles.

Source files
------------

// File: rtl/rv32_mem_bridge_if.sv
// rv32_mem_bridge_if: core memory handshake plus flat slave bus seen by the bridge
interface rv32_mem_bridge_if #(
  parameter int address_width = 32,
  parameter int data_width = 32
);
  logic mem_valid;
  logic [address_width-1:0] mem_addr;
  logic [data_width-1:0] mem_wdata;
  logic [3:0] mem_wstrb;
  logic mem_ready;
  logic [data_width-1:0] mem_rdata;
  logic [address_width-1:0] bus_addr;
  logic [3:0] bus_wr;
  logic [data_width-1:0] bus_din;
  logic [data_width-1:0] bus_dout;
  modport master (
    output mem_valid, mem_addr, mem_wdata, mem_wstrb, bus_dout,
    input mem_ready, mem_rdata, bus_addr, bus_wr, bus_din
  );
  modport slave (
    input mem_valid, mem_addr, mem_wdata, mem_wstrb, bus_dout,
    output mem_ready, mem_rdata, bus_addr, bus_wr, bus_din
  );
endinterface

// File: rtl/rv32_mem_bridge.sv
// rv32_mem_bridge: sequential bridge from the core mem_valid/mem_ready handshake to the flat slave bus
module rv32_mem_bridge #(
  parameter int address_width = 32,
  parameter int data_width = 32,
  parameter int read_latency = 1,
  parameter logic [address_width-1:0] MapBase = '0,
  parameter logic [address_width-1:0] MapEnd = 32'h0000_FFFF,
  parameter logic [data_width-1:0] ErrorData = 32'hDEAD_BEEF
) (
  input logic clk,
  input logic reset,
  rv32_mem_bridge_if.slave br,
  output logic [7:0] err_count,
  output logic [address_width-1:0] err_addr
);
  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;
  state_t state, state_n;
  logic [address_width-1:0] req_addr;
  logic [data_width-1:0] req_wdata;
  logic [3:0] req_wstrb;
  logic hit;
  logic [3:0] cnt;
  // state register
  always_ff @(posedge clk) state <= reset ? IDLE : state_n;
  // next-state: one ACCESS cycle, reads wait out the slave latency, every request ends in one RESP cycle
  always_comb begin
    state_n = state == IDLE   ? (br.mem_valid ? ACCESS : IDLE) :
              state == ACCESS ? (|req_wstrb ? RESP : WAIT) :
              state == WAIT   ? (cnt == '0 ? RESP : WAIT) : IDLE;
  end
  // bus is driven from the latched request; write enables only in ACCESS and only inside the window
  assign br.bus_addr = state == IDLE ? '0 : req_addr;
  assign br.bus_din = state == IDLE ? '0 : req_wdata;
  assign br.bus_wr = state == ACCESS && hit ? req_wstrb : '0;
  assign br.mem_ready = state == RESP;
  // request latch, read-latency counter, read capture and unmapped-access logging
  always_ff @(posedge clk) begin
    if (reset) begin
      req_addr <= '0;
      req_wdata <= '0;
      req_wstrb <= '0;
      hit <= 1'b0;
      cnt <= '0;
      br.mem_rdata <= '0;
      err_count <= '0;
      err_addr <= '0;
    end else begin
      if (state == IDLE && br.mem_valid) begin
        req_addr <= br.mem_addr;
        req_wdata <= br.mem_wdata;
        req_wstrb <= br.mem_wstrb;
        hit <= (br.mem_addr - MapBase) <= (MapEnd - MapBase);
      end
      if (state == ACCESS) cnt <= 4'(read_latency - 1);
      if (state == WAIT) cnt <= cnt - 4'd1;
      if (state == ACCESS && !hit) begin
        err_addr <= req_addr;
        err_count <= err_count + {7'd0, err_count != 8'hFF};
      end
      if (state == WAIT && cnt == '0) br.mem_rdata <= hit ? br.bus_dout : ErrorData;
    end
  end
endmodule

// File: tb/tb_rv32_mem_bridge.sv
// tb_rv32_mem_bridge: directed table, random traffic vs. a transaction model, and multi-cycle corner cases
module tb_rv32_mem_bridge;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0] rst_d, valid, ready;
  logic [1:0][31:0] addr_d, wdata_d, rdata_o, baddr, bdin, eaddr_o;
  logic [1:0][3:0] strb_d, bwr;
  logic [1:0][7:0] ecnt_o;
  int checks = 0, failures = 0;

  logic [31:0] mdl [2][256];
  int mcnt [2];
  logic [31:0] meaddr [2], mlast [2];

  for (genvar g = 0; g < 2; g++) begin : u
    rv32_mem_bridge_if bif ();
    logic [31:0] ram [256];
    logic [31:0] rdq;
    rv32_mem_bridge #(.read_latency(g == 0 ? 1 : 4)) dut (
      .clk(clk), .reset(rst_d[g]), .br(bif), .err_count(ecnt_o[g]), .err_addr(eaddr_o[g])
    );
    assign bif.mem_valid = valid[g];
    assign bif.mem_addr = addr_d[g];
    assign bif.mem_wdata = wdata_d[g];
    assign bif.mem_wstrb = strb_d[g];
    assign bif.bus_dout = rdq;
    assign ready[g] = bif.mem_ready;
    assign rdata_o[g] = bif.mem_rdata;
    assign baddr[g] = bif.bus_addr;
    assign bdin[g] = bif.bus_din;
    assign bwr[g] = bif.bus_wr;
    always @(posedge clk) begin
      rdq <= ram[bif.bus_addr[9:2]];
      for (int k = 0; k < 4; k++)
        if (bif.bus_wr[k]) ram[bif.bus_addr[9:2]][8*k +: 8] <= bif.bus_din[8*k +: 8];
    end
  end

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0] st;
    logic [31:0] exp_rd;
    int exp_lat;
    int exp_cnt;
  } vec_t;
  vec_t tbl [12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic req(input int s, input logic [31:0] a, input logic [31:0] d, input logic [3:0] st,
                     output int lat, output logic [31:0] rd);
    int wrp = 0, wrc = 0, bad = 0;
    logic [3:0] wrv = '0;
    bit mapped = a <= 32'h0000_FFFF;
    int exp_lat = st != 0 ? 2 : (s == 0 ? 3 : 6);
    lat = 0;
    @(negedge clk);
    valid[s] = 1'b1; addr_d[s] = a; wdata_d[s] = d; strb_d[s] = st;
    @(posedge clk);
    #1;
    addr_d[s] = $urandom; wdata_d[s] = $urandom; strb_d[s] = 4'($urandom);
    for (int c = 1; c <= 30 && lat == 0; c++) begin
      @(negedge clk);
      if (bwr[s] != 0) begin wrp++; wrv = bwr[s]; wrc = c; end
      if (baddr[s] != a || bdin[s] != d) bad++;
      if (ready[s]) lat = c;
    end
    valid[s] = 1'b0;
    if (!mapped) begin
      mcnt[s] = mcnt[s] < 255 ? mcnt[s] + 1 : 255;
      meaddr[s] = a;
    end else if (st != 0) begin
      for (int k = 0; k < 4; k++) if (st[k]) mdl[s][a[9:2]][8*k +: 8] = d[8*k +: 8];
    end
    if (st == 0) mlast[s] = mapped ? mdl[s][a[9:2]] : 32'hDEAD_BEEF;
    rd = rdata_o[s];
    check("latency", lat, exp_lat);
    check("rdata", rd, mlast[s]);
    check("wr_pulses", wrp, (mapped && st != 0) ? 1 : 0);
    if (mapped && st != 0) begin
      check("wr_value", {28'd0, wrv}, {28'd0, st});
      check("wr_cycle", wrc, 1);
    end
    check("bus_hold", bad, 0);
    check("err_count", {24'd0, ecnt_o[s]}, mcnt[s]);
    check("err_addr", eaddr_o[s], meaddr[s]);
    @(negedge clk);
    check("idle_ready", {31'd0, ready[s]}, 0);
    check("idle_bus", baddr[s] | bdin[s] | {28'd0, bwr[s]}, 0);
  endtask

  initial begin
    int lat, first, second, pulses;
    logic [31:0] rd, a;
    logic [3:0] st;
    rst_d = '1; valid = '0; addr_d = '0; wdata_d = '0; strb_d = '0;
    for (int s = 0; s < 2; s++) begin mcnt[s] = 0; meaddr[s] = '0; mlast[s] = '0; end
    tbl[0]  = '{32'h0000_0010, 32'hA5A5_1234, 4'b0011, 32'h0, 2, 0};
    tbl[1]  = '{32'h0000_0010, 32'hCAFE_F00D, 4'b1111, 32'h0, 2, 0};
    tbl[2]  = '{32'h0000_0010, 32'h0, 4'b0000, 32'hCAFE_F00D, 3, 0};
    tbl[3]  = '{32'h0000_0020, 32'hFFFF_FFFF, 4'b1111, 32'h0, 2, 0};
    tbl[4]  = '{32'h0000_0020, 32'h1234_5678, 4'b0101, 32'h0, 2, 0};
    tbl[5]  = '{32'h0000_0020, 32'h0, 4'b0000, 32'hFF34_FF78, 3, 0};
    tbl[6]  = '{32'h0001_0000, 32'h0, 4'b0000, 32'hDEAD_BEEF, 3, 1};
    tbl[7]  = '{32'hFFFF_FFFC, 32'h0BAD_F00D, 4'b1111, 32'h0, 2, 2};
    tbl[8]  = '{32'h0000_FFFC, 32'h5566_7788, 4'b1111, 32'h0, 2, 2};
    tbl[9]  = '{32'h0000_FFFC, 32'h0, 4'b0000, 32'h5566_7788, 3, 2};
    tbl[10] = '{32'h0000_FFFF, 32'h0, 4'b0000, 32'h5566_7788, 3, 2};
    tbl[11] = '{32'h0001_0000, 32'h7777_7777, 4'b1111, 32'h0, 2, 3};
    repeat (2) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      check("rst_ready", {31'd0, ready[s]}, 0);
      check("rst_rdata", rdata_o[s], 0);
      check("rst_bus", baddr[s] | bdin[s] | {28'd0, bwr[s]}, 0);
      check("rst_err", eaddr_o[s] | {24'd0, ecnt_o[s]}, 0);
    end
    rst_d = '0;
    for (int i = 0; i < 12; i++) begin
      req(0, tbl[i].a, tbl[i].d, tbl[i].st, lat, rd);
      check("tbl_lat", lat, tbl[i].exp_lat);
      if (tbl[i].st == 0) check("tbl_rdata", rd, tbl[i].exp_rd);
      check("tbl_err_count", {24'd0, ecnt_o[0]}, tbl[i].exp_cnt);
    end
    check("tbl_err_addr", eaddr_o[0], 32'h0001_0000);
    for (int s = 0; s < 2; s++)
      for (int w = 0; w < 16; w++) req(s, 32'(w * 4), $urandom, 4'hF, lat, rd);
    for (int i = 0; i < 110; i++) begin
      a = $urandom_range(0, 3) == 0 ? ($urandom | 32'h0001_0000) : 32'($urandom_range(0, 15) * 4);
      st = $urandom_range(0, 1) == 0 ? 4'd0 : 4'($urandom_range(1, 15));
      req(i < 80 ? 0 : 1, a, $urandom, st, lat, rd);
    end
    req(1, 32'h40, 32'h1111_2222, 4'hF, lat, rd);
    req(1, 32'h40, 32'h0, 4'h0, lat, rd);
    check("rl4_lat", lat, 6);
    check("rl4_rdata", rd, 32'h1111_2222);
    for (int i = 0; i < 300; i++) req(0, 32'h0002_0000 + 32'(i * 4), $urandom, 4'hF, lat, rd);
    check("err_sat", {24'd0, ecnt_o[0]}, 32'hFF);
    @(negedge clk);
    valid[0] = 1'b1; addr_d[0] = 32'h10; strb_d[0] = 4'h0;
    @(negedge clk);
    @(negedge clk);
    check("wait_no_ready", {31'd0, ready[0]}, 0);
    rst_d[0] = 1'b1; valid[0] = 1'b0;
    @(negedge clk);
    check("wrst_ready", {31'd0, ready[0]}, 0);
    check("wrst_rdata", rdata_o[0], 0);
    check("wrst_bus", baddr[0] | bdin[0] | {28'd0, bwr[0]}, 0);
    check("wrst_err_count", {24'd0, ecnt_o[0]}, 0);
    check("wrst_err_addr", eaddr_o[0], 0);
    rst_d[0] = 1'b0;
    mcnt[0] = 0; meaddr[0] = '0; mlast[0] = '0;
    req(0, 32'h30, 32'h9999_0000, 4'hF, lat, rd);
    check("post_rst_lat", lat, 2);
    first = 0; second = 0; pulses = 0;
    @(negedge clk);
    valid[0] = 1'b1; addr_d[0] = 32'h10; strb_d[0] = 4'h0;
    for (int c = 1; c <= 20 && pulses < 2; c++) begin
      @(negedge clk);
      if (ready[0]) begin
        pulses++;
        if (pulses == 1) first = c; else second = c;
      end
    end
    valid[0] = 1'b0;
    mlast[0] = mdl[0][4];
    check("b2b_rdata", rdata_o[0], mlast[0]);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (ready[0]) pulses++;
    end
    check("b2b_pulses", pulses, 2);
    check("b2b_first", first, 3);
    check("b2b_spacing", second - first, 4);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
